// File: rtl/lane_logic_pipe_pkg.sv
// Shared op codes and the per-bit lane operation for lane_logic_pipe and its bench.
package lane_logic_pkg;

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_NAND = 2'd3;

  // One result bit; a lane applies this to every bit position independently.
  function automatic logic lane_op(input logic a, input logic b, input logic [1:0] op);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = ~(a & b);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lane_logic_pipe_if.sv
// Operand/result bundle for lane_logic_pipe; parity present only with LANE_LOGIC_PIPE_PARITY_EN.
//
// Handshake: a beat moves across a channel on a rising clk edge where valid && ready.
// The sender keeps valid and its data stable until that edge; ready may depend
// combinationally on the receiver's state and on out_ready, never on in_valid.
interface lane_logic_pipe_if #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 1
);
  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_LANES*LANE_W-1:0] a;
  logic [NUM_LANES*LANE_W-1:0] b;
  logic [NUM_LANES*2-1:0]      op;
  logic                        out_valid;
  logic                        out_ready;
  logic [NUM_LANES*LANE_W-1:0] c;
`ifdef LANE_LOGIC_PIPE_PARITY_EN
  logic [NUM_LANES-1:0]        parity;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, c, parity
  );
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, c, parity
  );
`else
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, c
  );
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, c
  );
`endif
endinterface

// File: rtl/lane_logic_pipe_cell.sv
// Combinational op for one LANE_W-bit lane.
module lane_logic_cell
  import lane_logic_pkg::*;
#(
  parameter int LANE_W = 1
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic [1:0]        op,
  output logic [LANE_W-1:0] c
);

  always_comb begin
    c = '0;
    for (int i = 0; i < LANE_W; i++) begin
      c[i] = lane_op(a[i], b[i], op);
    end
  end

endmodule

// File: rtl/lane_logic_pipe.sv
// Two-stage valid/ready lane logic pipeline with a saturating accept counter.
// Optional per-lane result parity output under LANE_LOGIC_PIPE_PARITY_EN.
module lane_logic_pipe
  import lane_logic_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  lane_logic_pipe_if.slave bus,
  output logic [CNT_W-1:0] txn_cnt
);

  localparam int DW = NUM_LANES * LANE_W;
  localparam int OW = NUM_LANES * 2;

  logic          s1_valid;
  logic [DW-1:0] s1_a;
  logic [DW-1:0] s1_b;
  logic [OW-1:0] s1_op;
  logic          s2_valid;
  logic [DW-1:0] s2_c;
  logic [DW-1:0] lane_res;

  logic s2_adv;
  logic in_rdy;
  logic accept;

  // s1 loads whenever it is empty or its beat moves on, so its load enable equals in_ready.
  assign s2_adv = !s2_valid || bus.out_ready;
  assign in_rdy = !rst_n || !s1_valid || s2_adv;
  assign accept = bus.in_valid && in_rdy;

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = s2_valid;
  assign bus.c         = s2_c;

  // Ops are evaluated from the registered op, so a changing op input cannot disturb held beats.
  lane_logic_cell #(.LANE_W(LANE_W)) u_cell [NUM_LANES-1:0] (
    .a  (s1_a),
    .b  (s1_b),
    .op (s1_op),
    .c  (lane_res)
  );

`ifdef LANE_LOGIC_PIPE_PARITY_EN
  logic [NUM_LANES-1:0] par_next;
  logic [NUM_LANES-1:0] s2_par;

  always_comb begin
    par_next = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      par_next[i] = ^lane_res[i*LANE_W +: LANE_W];
    end
  end

  assign bus.parity = s2_par;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_par <= '0;
    end else if (s2_adv && s1_valid) begin
      s2_par <= par_next;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s2_valid <= 1'b0;
      s2_c     <= '0;
      txn_cnt  <= '0;
    end else begin
      // c keeps its last value while empty; it only loads a real beat.
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_c <= lane_res;
        end
      end
      if (in_rdy) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_a  <= bus.a;
          s1_b  <= bus.b;
          s1_op <= bus.op;
        end
      end
      if (accept && (txn_cnt != {CNT_W{1'b1}})) begin
        txn_cnt <= txn_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lane_logic_pipe.sv
// Directed bench for lane_logic_pipe: default build, a CNT_W=2 copy and a LANE_W=4 copy.
module tb_lane_logic_pipe;
  import lane_logic_pkg::*;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] txn0;
  logic [1:0] txn1;
  logic [7:0] txn2;

  logic [3:0] exp_q[$];
  logic [3:0] beats[4];
  logic [3:0] exp_v;
  int         idx;
  int         n_out;

  lane_logic_pipe_if #(.NUM_LANES(4), .LANE_W(1)) bus0 ();
  lane_logic_pipe_if #(.NUM_LANES(4), .LANE_W(1)) bus1 ();
  lane_logic_pipe_if #(.NUM_LANES(4), .LANE_W(4)) bus2 ();

  lane_logic_pipe #(.NUM_LANES(4), .LANE_W(1), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .txn_cnt(txn0)
  );
  lane_logic_pipe #(.NUM_LANES(4), .LANE_W(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .txn_cnt(txn1)
  );
  lane_logic_pipe #(.NUM_LANES(4), .LANE_W(4), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .txn_cnt(txn2)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.op = '0; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.op = '0; bus1.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.op = '0; bus2.out_ready = 1'b1;
  endtask

  initial begin
    idle_all();
    rst_n = 1'b0;
    beats[0] = 4'b0001; beats[1] = 4'b0010; beats[2] = 4'b0100; beats[3] = 4'b1000;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus0.out_valid, 0);
    check("rst_c",         bus0.c, 0);
    check("rst_txn",       txn0, 0);
    check("rst_in_ready",  bus0.in_ready, 1);
`ifdef LANE_LOGIC_PIPE_PARITY_EN
    check("rst_parity",    bus2.parity, 0);
`endif
    rst_n = 1'b1;

    // single AND beat: 1100 & 1010 = 1000, visible two edges after accept
    bus0.in_valid = 1'b1; bus0.a = 4'b1100; bus0.b = 4'b1010; bus0.op = 8'h00;
    @(negedge clk);
    bus0.in_valid = 1'b0;
    check("t1_lat1_valid", bus0.out_valid, 0);
    @(negedge clk);
    check("t1_out_valid",  bus0.out_valid, 1);
    check("t1_c",          bus0.c, 4'b1000);
    check("t1_txn",        txn0, 1);
    @(negedge clk);
    check("t1_drained",    bus0.out_valid, 0);

    // per-lane ops lane3..0 = NAND,XOR,OR,AND; a=1111 b=0101
    // lane3 ~(1&0)=1, lane2 1^1=0, lane1 1|0=1, lane0 1&1=1 -> 1011
    bus0.in_valid = 1'b1; bus0.a = 4'b1111; bus0.b = 4'b0101;
    bus0.op = {OP_NAND, OP_XOR, OP_OR, OP_AND};
    @(negedge clk);
    bus0.in_valid = 1'b0;
    @(negedge clk);
    check("t2_out_valid",  bus0.out_valid, 1);
    check("t2_c",          bus0.c, 4'b1011);
    @(negedge clk);

    // 4-beat XOR stream (b=0 so c=a) against a stalled consumer, then release
    bus0.b = 4'b0000;
    idx = 0;
    n_out = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      bus0.out_ready = (cyc >= 5);
      // op is scrambled to AND while beats are held; held results must not change
      bus0.op = (cyc >= 2 && cyc <= 4) ? 8'h00 : 8'hAA;
      if (idx < 4) begin
        bus0.in_valid = 1'b1;
        bus0.a = beats[idx];
      end else begin
        bus0.in_valid = 1'b0;
      end
      #1;
      if (cyc == 2) begin
        check("t3_in_ready_full", bus0.in_ready, 0);
        check("t3_hold_valid",    bus0.out_valid, 1);
        check("t3_hold_c0",       bus0.c, beats[0]);
      end
      if (cyc == 4) begin
        check("t3_hold_c2",       bus0.c, beats[0]);
        check("t3_still_full",    bus0.in_ready, 0);
      end
      if (bus0.out_valid && bus0.out_ready) begin
        if (exp_q.size() > 0) begin
          exp_v = exp_q.pop_front();
          check("t3_order", bus0.c, exp_v);
        end else begin
          check("t3_extra", bus0.out_valid, 0);
        end
        n_out++;
      end
      if (bus0.in_valid && bus0.in_ready) begin
        exp_q.push_back(bus0.a);
        idx++;
      end
      @(negedge clk);
    end
    check("t3_count",    n_out, 4);
    check("t3_q_empty",  exp_q.size(), 0);
    check("t3_txn",      txn0, 6);

    // fill both stages, then a one-cycle reset
    bus0.out_ready = 1'b0; bus0.op = 8'hAA;
    bus0.in_valid = 1'b1; bus0.a = 4'b0011;
    @(negedge clk);
    bus0.a = 4'b0110;
    @(negedge clk);
    bus0.in_valid = 1'b0;
    check("t5_pre_full", bus0.in_ready, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_out_valid", bus0.out_valid, 0);
    check("t5_c",         bus0.c, 0);
    check("t5_txn",       txn0, 0);
    check("t5_in_ready",  bus0.in_ready, 1);
    rst_n = 1'b1;
    bus0.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_no_ghost", bus0.out_valid, 0);
    end

    // CNT_W=2 counter saturates at 3 over 5 accepts
    bus1.in_valid = 1'b1; bus1.a = 4'b0101; bus1.op = 8'hFF;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("t6_sat", txn1, (k > 3) ? 3 : k);
    end
    bus1.in_valid = 1'b0;
    @(negedge clk);
    check("t6_sat_hold", txn1, 3);

    // LANE_W=4: lane0 1011 & 1111 = 1011, other lanes 0
    bus2.in_valid = 1'b1; bus2.a = 16'h000B; bus2.b = 16'h000F; bus2.op = 8'h00;
    @(negedge clk);
    bus2.in_valid = 1'b0;
    @(negedge clk);
    check("t7_valid", bus2.out_valid, 1);
    check("t7_c",     bus2.c, 16'h000B);
`ifdef LANE_LOGIC_PIPE_PARITY_EN
    check("t7_parity", bus2.parity, 4'b0001);
`endif
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
